// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional performance counters are built only when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c_PCWrite,
  input  logic             c_IFIDWrite,
  input  logic             IF_Flush,
  input  logic             id_jump,
  input  logic [25:0]      id_jump_index,
  input  logic             id_branch_taken,
  input  logic [31:0]      id_branch_target,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instru,
  output logic [31:0]      if_id_pc_plus4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] pc_next;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  assign pc_plus4      = pc_q + 32'd4;
  // The jump in ID takes its region bits from its own PC+4, held in IF/ID.
  assign jump_target   = {pc_plus4_q[31:28], id_jump_index, 2'b00};
  assign branch_target = id_branch_target & 32'hFFFF_FFFC;

  // A held PC discards any redirect; jump outranks branch.
  always_comb begin
    pc_next = pc_q;
    if (c_PCWrite) begin
      if (id_jump) begin
        pc_next = jump_target;
      end else if (id_branch_taken) begin
        pc_next = branch_target;
      end else begin
        pc_next = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // A held IF/ID also ignores IF_Flush so a stalled instruction is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else if (c_IFIDWrite) begin
      pc_plus4_q <= pc_plus4;
      if (IF_Flush) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else begin
        instr_q <= imem_instr;
        valid_q <= 1'b1;
      end
    end
  end

  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign if_id_instru   = instr_q;
  assign if_id_pc_plus4 = pc_plus4_q;
  assign if_id_valid    = valid_q;

`ifdef IF_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!c_PCWrite && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (IF_Flush && c_IFIDWrite && (flush_q != CNT_MAX)) begin
        flush_q <= flush_q + CNT_ONE;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
